// File: rtl/decode_ctrl_stage.sv
// Registered ID-stage control decoder for RV32I/RV64I with a 2-entry skid buffer on the output.
// Optional feature macro: DECODE_MULDIV_EN (M-extension funct7=0000001 decodes legal with alu_op=11).
module decode_ctrl_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_pc,
    output logic             jump,
    output logic             is_branch,
    output logic             mem_write,
    output logic             mreq,
    output logic             alu_src,
    output logic             reg_write,
    output logic             is_utype,
    output logic             is_lui,
    output logic             is_word,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_src,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic [1:0]       o_dbg_state
);

    // Handshake: a transfer happens on a port in any cycle where its valid and ready are both high.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic            jump;
        logic            is_branch;
        logic            mem_write;
        logic            mreq;
        logic            alu_src;
        logic            reg_write;
        logic            is_utype;
        logic            is_lui;
        logic            is_word;
        logic [1:0]      result_src;
        logic [2:0]      imm_src;
        logic [1:0]      alu_op;
        logic            illegal;
    } entry_t;

    logic [1:0]       r_state;
    logic             r_in_ready;
    entry_t           r_out;
    entry_t           r_skid;
    logic [CNT_W-1:0] r_cnt;

    entry_t           w_dec;
    logic [6:0]       w_opcode;
    logic [6:0]       w_funct7;
    logic             w_muldiv;
    logic             w_f7_ok;
    logic             w_accept;

    assign w_opcode = in_inst[6:0];
    assign w_funct7 = in_inst[31:25];
`ifdef DECODE_MULDIV_EN
    assign w_muldiv = (w_funct7 == 7'b0000001);
`else
    assign w_muldiv = 1'b0;
`endif
    assign w_f7_ok  = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000) || w_muldiv;
    assign w_accept = in_valid && r_in_ready && !flush;

    always_comb begin
        w_dec      = '0;
        w_dec.inst = in_inst;
        w_dec.pc   = in_pc;
        case (w_opcode)
            OPC_LOAD: begin
                w_dec.mreq = 1'b1; w_dec.reg_write = 1'b1; w_dec.result_src = 2'b01; w_dec.alu_src = 1'b1;
            end
            OPC_OPIMM: begin
                w_dec.reg_write = 1'b1; w_dec.alu_op = 2'b10; w_dec.alu_src = 1'b1;
            end
            OPC_JALR: begin
                w_dec.jump = 1'b1; w_dec.reg_write = 1'b1; w_dec.result_src = 2'b10; w_dec.alu_src = 1'b1;
            end
            OPC_STORE: begin
                w_dec.imm_src = 3'b001; w_dec.mreq = 1'b1; w_dec.mem_write = 1'b1; w_dec.alu_src = 1'b1;
            end
            OPC_OP: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_op    = w_muldiv ? 2'b11 : 2'b10;
                w_dec.illegal   = !w_f7_ok;
            end
            OPC_BRANCH: begin
                w_dec.imm_src = 3'b010; w_dec.is_branch = 1'b1; w_dec.alu_op = 2'b01;
            end
            OPC_JAL: begin
                w_dec.imm_src = 3'b011; w_dec.jump = 1'b1; w_dec.reg_write = 1'b1; w_dec.result_src = 2'b10;
            end
            OPC_AUIPC, OPC_LUI: begin
                w_dec.imm_src = 3'b100; w_dec.reg_write = 1'b1; w_dec.is_utype = 1'b1;
                w_dec.result_src = 2'b11; w_dec.alu_src = 1'b1;
                w_dec.is_lui = (w_opcode == OPC_LUI);
            end
            // Word opcodes only exist on RV64; on RV32 they decode like any unknown opcode.
            OPC_OPIMM32: begin
                if (XLEN == 64) begin
                    w_dec.reg_write = 1'b1; w_dec.alu_op = 2'b10; w_dec.alu_src = 1'b1; w_dec.is_word = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OPC_OP32: begin
                if (XLEN == 64) begin
                    w_dec.reg_write = 1'b1; w_dec.is_word = 1'b1;
                    w_dec.alu_op    = w_muldiv ? 2'b11 : 2'b10;
                    w_dec.illegal   = !w_f7_ok;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            default: w_dec.illegal = 1'b1;
        endcase
        // Illegal entries still travel to EX for the trap but must not cause side effects.
        if (w_dec.illegal) begin
            w_dec.reg_write = 1'b0;
            w_dec.mem_write = 1'b0;
            w_dec.mreq      = 1'b0;
            w_dec.jump      = 1'b0;
            w_dec.is_branch = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
            r_out      <= '0;
            r_skid     <= '0;
            r_cnt      <= '0;
        end else if (flush) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_out   <= w_dec;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && out_ready) begin
                        r_out <= w_dec;
                    end else if (w_accept) begin
                        r_skid     <= w_dec;
                        r_state    <= S_FULL;
                        r_in_ready <= 1'b0;
                    end else if (out_ready) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        r_out      <= r_skid;
                        r_state    <= S_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
            if (w_accept && w_dec.illegal && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != S_EMPTY);
    assign out_inst    = r_out.inst;
    assign out_pc      = r_out.pc;
    assign jump        = r_out.jump;
    assign is_branch   = r_out.is_branch;
    assign mem_write   = r_out.mem_write;
    assign mreq        = r_out.mreq;
    assign alu_src     = r_out.alu_src;
    assign reg_write   = r_out.reg_write;
    assign is_utype    = r_out.is_utype;
    assign is_lui      = r_out.is_lui;
    assign is_word     = r_out.is_word;
    assign result_src  = r_out.result_src;
    assign imm_src     = r_out.imm_src;
    assign alu_op      = r_out.alu_op;
    assign illegal     = r_out.illegal;
    assign illegal_cnt = r_cnt;
    assign o_dbg_state = r_state;

endmodule
